logic_unit_arbiter: RTL and testbench

Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters in the ALU datapath. Requests arrive on valid/ready ports, a round-robin arbiter picks one, and a three-state FSM sequences accept, execute and respond. Results go out on a single registered valid/ready response port tagged with the requester id. A 16-bit completed-operation counter supports debug and performance checks.

---
 rtl/logic_unit_arbiter_pkg.sv | 16 +
 rtl/logic_unit_arbiter_if.sv | 41 ++++
 rtl/logic_unit_arbiter_logic_32bit.sv | 32 +++
 rtl/logic_unit_arbiter.sv | 108 ++++++++++
 tb/tb_logic_unit_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared op codes and FSM encodings for the
// two-requester bitwise logic unit arbiter.
package logic_unit_arbiter_pkg;

    localparam logic [1:0] LOP_AND = 2'b00;
    localparam logic [1:0] LOP_OR  = 2'b01;
    localparam logic [1:0] LOP_XOR = 2'b10;
    localparam logic [1:0] LOP_NOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response handshake bundle between the
// two requesters, the result consumer and the arbiter.
interface logic_unit_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_rs;
    logic [WIDTH-1:0] req0_rt;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_rs;
    logic [WIDTH-1:0] req1_rt;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_rd;
    logic             rsp_zero;

    modport master (
        output req0_valid, req0_op, req0_rs, req0_rt,
        input  req0_ready,
        output req1_valid, req1_op, req1_rs, req1_rt,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_rd, rsp_zero,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_rs, req0_rt,
        output req0_ready,
        input  req1_valid, req1_op, req1_rs, req1_rt,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_rd, rsp_zero,
        input  rsp_ready
    );
endinterface

// File: rtl/logic_unit_arbiter_logic_32bit.sv
// Combinational bitwise logic unit: AND/OR/XOR/NOR
// computed in parallel, one selected by op.
module logic_32bit
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    output logic [WIDTH-1:0] rd,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [1:0]       op
);
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_nor;

    assign w_and = rs & rt;
    assign w_or  = rs | rt;
    assign w_xor = rs ^ rt;
    assign w_nor = ~(rs | rt);

    always_comb begin
        rd = w_and;
        unique case (op)
            LOP_AND: rd = w_and;
            LOP_OR:  rd = w_or;
            LOP_XOR: rd = w_xor;
            LOP_NOR: rd = w_nor;
        endcase
    end
endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit between two
// requesters, with a registered tagged response port.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    logic_unit_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]     op_count
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           r_state;
    state_e           w_next;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_rs;
    logic [WIDTH-1:0] r_rt;
    logic             r_id;
    logic             r_last_grant;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic             r_rsp_zero;
    logic [WIDTH-1:0] r_rsp_rd;
    logic [CNT_W-1:0] r_op_count;

    logic             w_grant;
    logic             w_accept;
    logic [WIDTH-1:0] w_rd;

    // On a tie the requester that did not win last time goes first
    always_comb begin
        w_grant = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            w_grant = ~r_last_grant;
    end

    assign w_accept = !reset && (r_state == ST_IDLE)
                      && (bus.req0_valid || bus.req1_valid);

    assign bus.req0_ready = w_accept && !w_grant;
    assign bus.req1_ready = w_accept &&  w_grant;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    logic_32bit #(.WIDTH(WIDTH)) u_logic (
        .rd (w_rd),
        .rs (r_rs),
        .rt (r_rt),
        .op (r_op)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op         <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_rd     <= '0;
            r_op_count   <= '0;
        end else begin
            if (w_accept) begin
                r_op         <= w_grant ? bus.req1_op : bus.req0_op;
                r_rs         <= w_grant ? bus.req1_rs : bus.req0_rs;
                r_rt         <= w_grant ? bus.req1_rt : bus.req0_rt;
                r_id         <= w_grant;
                r_last_grant <= w_grant;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_rd    <= w_rd;
                r_rsp_zero  <= (w_rd == '0);
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end
            if (r_state == ST_RESP && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_op_count  <= r_op_count + CNT_ONE;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_rd    = r_rsp_rd;
    assign bus.rsp_zero  = r_rsp_zero;
    assign op_count      = r_op_count;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed plus randomized checks of the logic unit arbiter
// against a transaction-level reference model.
module tb_logic_unit_arbiter;
    localparam int TB_CNT_W = 6;
    localparam int CNT_MOD  = 1 << TB_CNT_W;

    logic                clk;
    logic                reset;
    logic [TB_CNT_W-1:0] op_count;

    int total = 0;
    int bad   = 0;
    int m_count;
    bit m_last;

    logic_unit_arbiter_if #(.WIDTH(32)) bus ();

    logic_unit_arbiter #(
        .WIDTH (32),
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_lop(
        input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    function automatic logic [63:0] exp_cnt();
        return 64'(m_count % CNT_MOD);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        m_count = 0;
        m_last  = 1'b1;
    endtask

    // One full request/response; called at a negedge with the DUT idle
    task automatic txn(input bit v0, input bit v1,
                       input logic [1:0] op0, input logic [1:0] op1,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input int hold);
        bit          win;
        logic [31:0] exp_rd;
        win = (v0 && v1) ? !m_last : v1;
        exp_rd = win ? ref_lop(op1, a1, b1) : ref_lop(op0, a0, b0);
        bus.req0_valid = v0;  bus.req0_op = op0;
        bus.req0_rs = a0;     bus.req0_rt = b0;
        bus.req1_valid = v1;  bus.req1_op = op1;
        bus.req1_rs = a1;     bus.req1_rt = b1;
        bus.rsp_ready = 1'b0;
        #1;
        chk("ready0", 64'(bus.req0_ready), 64'(!win));
        chk("ready1", 64'(bus.req1_ready), 64'(win));
        m_last = win;
        @(negedge clk);
        if (win) bus.req1_rs = $urandom;
        else     bus.req0_rs = $urandom;
        bus.rsp_ready = (hold == 0);
        #1;
        chk("exec_valid", 64'(bus.rsp_valid), 64'd0);
        chk("exec_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        @(negedge clk);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("rsp_id", 64'(bus.rsp_id), 64'(win));
        chk("rsp_rd", 64'(bus.rsp_rd), 64'(exp_rd));
        chk("rsp_zero", 64'(bus.rsp_zero), 64'(exp_rd == 32'd0));
        chk("cnt_hold", 64'(op_count), exp_cnt());
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_rd", 64'(bus.rsp_rd), 64'(exp_rd));
            chk("bp_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
            chk("bp_cnt", 64'(op_count), exp_cnt());
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        m_count++;
        chk("done_valid", 64'(bus.rsp_valid), 64'd0);
        chk("done_cnt", 64'(op_count), exp_cnt());
    endtask

    task automatic rand_txn(input bit both, input int hold);
        int r;
        r = both ? 3 : $urandom_range(1, 3);
        txn(r[0], r[1], 2'($urandom), 2'($urandom),
            $urandom, $urandom, $urandom, $urandom, hold);
    endtask

    initial begin
        reset = 1'b1;
        bus.req0_valid = 1'b1;  bus.req1_valid = 1'b1;
        bus.req0_op = 2'b00;    bus.req1_op = 2'b00;
        bus.req0_rs = '0;       bus.req0_rt = '0;
        bus.req1_rs = '0;       bus.req1_rt = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        do_reset();
        #1;
        chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rd", 64'(bus.rsp_rd), 64'd0);
        chk("rst_zero", 64'(bus.rsp_zero), 64'd0);
        chk("rst_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_cnt", 64'(op_count), 64'd0);

        txn(1, 0, 2'b01, 2'b00, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 0);

        do_reset();
        txn(1, 1, 2'b00, 2'b10, 32'h0F80_0000, 32'hFFFF_FFFF,
            32'h1234_5678, 32'h1234_5678, 0);
        txn(1, 1, 2'b00, 2'b10, 32'h0F80_0000, 32'hFFFF_FFFF,
            32'h1234_5678, 32'h1234_5678, 0);

        for (int i = 0; i < 6; i++) rand_txn(1'b1, 0);

        txn(1, 0, 2'b11, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5);

        for (int i = 0; i < 20; i++)
            rand_txn(1'b0, int'($urandom_range(0, 3)));

        bus.req0_valid = 1'b1;  bus.req0_op = 2'b01;
        bus.req0_rs = 32'hA5A5_0000;  bus.req0_rt = 32'h0000_5A5A;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 64'(bus.rsp_valid), 64'd1);
        chk("pre_rst_cnt", 64'(op_count), exp_cnt());
        reset = 1'b1;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("midrst_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        m_count = 0;
        m_last  = 1'b1;
        #1;
        chk("midrst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midrst_cnt", 64'(op_count), 64'd0);
        chk("midrst_rd", 64'(bus.rsp_rd), 64'd0);
        @(negedge clk);
        txn(1, 1, 2'b10, 2'b01, 32'hFFFF_0000, 32'h00FF_FF00,
            32'h0000_0001, 32'h0000_0002, 0);

        while (m_count < CNT_MOD) rand_txn(1'b0, 0);
        chk("wrap", 64'(op_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
